// File: rtl/blink_sense.sv
// rtl/blink_sense.sv - blink input half-period meter with stall timeout (optional lock: BLINK_SENSE_LOCK_EN)
module blink_sense #(
    parameter logic [31:0] TIMEOUT = 32'd50_000_000,
    parameter int unsigned LOCK_N  = 4,
    parameter logic [31:0] TOL     = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    output logic [31:0] period,
    output logic        valid,
    output logic        level,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        s1, s2, s3;
    logic        edge_det;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] period_nxt;
    logic        valid_nxt;
    logic        timeout_nxt;

    assign edge_det = s2 ^ s3;
    assign level    = s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // An edge always wins over a coincident timeout, so period can equal TIMEOUT.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (edge_det) begin
                    state_nxt   = MEASURE;
                    timeout_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    period_nxt = cnt + 32'd1;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt == TIMEOUT - 32'd1) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            period  <= period_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
        end
    end

`ifdef BLINK_SENSE_LOCK_EN
    localparam int unsigned    SW       = $clog2(LOCK_N + 1);
    localparam logic [SW-1:0]  LOCK_MAX = SW'(LOCK_N);

    logic [SW-1:0] stab, stab_nxt;
    logic          primed, primed_nxt;
    logic [31:0]   diff;

    // The first measurement after arming has no meaningful predecessor.
    always_comb begin
        stab_nxt   = stab;
        primed_nxt = primed;
        diff       = (period_nxt >= period) ? (period_nxt - period) : (period - period_nxt);
        if (state_nxt == IDLE) begin
            stab_nxt   = '0;
            primed_nxt = 1'b0;
        end else if (valid_nxt) begin
            if (!primed) begin
                primed_nxt = 1'b1;
            end else if (diff <= TOL) begin
                if (stab != LOCK_MAX) begin
                    stab_nxt = stab + SW'(1);
                end
            end else begin
                stab_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab   <= '0;
            primed <= 1'b0;
            locked <= 1'b0;
        end else begin
            stab   <= stab_nxt;
            primed <= primed_nxt;
            locked <= (stab_nxt == LOCK_MAX);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{LOCK_N, TOL};
    assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_blink_sense.sv
// tb/tb_blink_sense.sv - randomized self-checking bench for blink_sense against an edge-timing model
module tb_blink_sense;

    localparam int TO_A   = 20;
    localparam int TO_B   = 1000;
    localparam int LOCK_N = 4;
    localparam int TOL    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in  = 1'b0;
    logic [31:0] period_a, period_b;
    logic        valid_a, valid_b, level_a, level_b;
    logic        timeout_a, timeout_b, locked_a, locked_b;

    blink_sense #(.TIMEOUT(32'(TO_A))) dut_a (
        .clk(clk), .rst(rst), .in(in), .period(period_a), .valid(valid_a),
        .level(level_a), .timeout(timeout_a), .locked(locked_a)
    );

    blink_sense #(.TIMEOUT(32'(TO_B)), .LOCK_N(LOCK_N), .TOL(32'(TOL))) dut_b (
        .clk(clk), .rst(rst), .in(in), .period(period_b), .valid(valid_b),
        .level(level_b), .timeout(timeout_b), .locked(locked_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: level follows `in` two samples late; outputs react to a level
    // change one cycle after it appears, using the cycle number of each change.
    int cyc;
    bit lev, d1, edge_prev;
    int to_lim [2] = '{TO_A, TO_B};
    bit armed  [2];
    bit vld    [2];
    bit tmo    [2];
    bit primed [2];
    bit lck    [2];
    int last   [2];
    int per    [2];
    int stab   [2];

    task automatic model_reset();
        cyc = 0; lev = 0; d1 = 0; edge_prev = 0;
        for (int i = 0; i < 2; i++) begin
            armed[i] = 0; vld[i] = 0; tmo[i] = 0; primed[i] = 0;
            lck[i] = 0; last[i] = 0; per[i] = 0; stab[i] = 0;
        end
    endtask

    task automatic lock_update(input int i, input int newp);
`ifdef BLINK_SENSE_LOCK_EN
        int d;
        if (!primed[i]) begin
            primed[i] = 1;
        end else begin
            d = newp - per[i];
            if (d < 0) d = -d;
            if (d <= TOL) stab[i] = (stab[i] < LOCK_N) ? stab[i] + 1 : stab[i];
            else stab[i] = 0;
        end
        lck[i] = (stab[i] == LOCK_N);
`else
        lck[i] = (newp < 0);
`endif
    endtask

    task automatic model_step();
        bit new_lev;
        int newp;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0;
            if (edge_prev) begin
                if (armed[i]) begin
                    newp = (cyc - 1) - last[i];
                    vld[i] = 1;
                    lock_update(i, newp);
                    per[i] = newp;
                end
                armed[i] = 1;
                last[i]  = cyc - 1;
                tmo[i]   = 0;
            end else if (armed[i] && ((cyc - 1) - last[i] == to_lim[i])) begin
                armed[i] = 0; tmo[i] = 1; stab[i] = 0; primed[i] = 0; lck[i] = 0;
            end
        end
        new_lev   = d1;
        d1        = in;
        edge_prev = (new_lev != lev);
        lev       = new_lev;
    endtask

    task automatic compare_all();
        check($sformatf("level@%0d", cyc),     32'(level_a),   32'(lev));
        check($sformatf("level_b@%0d", cyc),   32'(level_b),   32'(lev));
        check($sformatf("valid_a@%0d", cyc),   32'(valid_a),   32'(vld[0]));
        check($sformatf("valid_b@%0d", cyc),   32'(valid_b),   32'(vld[1]));
        check($sformatf("period_a@%0d", cyc),  period_a,       32'(per[0]));
        check($sformatf("period_b@%0d", cyc),  period_b,       32'(per[1]));
        check($sformatf("timeout_a@%0d", cyc), 32'(timeout_a), 32'(tmo[0]));
        check($sformatf("timeout_b@%0d", cyc), 32'(timeout_b), 32'(tmo[1]));
        check($sformatf("locked_a@%0d", cyc),  32'(locked_a),  32'(lck[0]));
        check($sformatf("locked_b@%0d", cyc),  32'(locked_b),  32'(lck[1]));
    endtask

    task automatic tick(input bit v);
        in = v;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    // Toggle the input and hold the new value for k cycles.
    task automatic half(input int k);
        bit v;
        v = !in;
        repeat (k) tick(v);
    endtask

    task automatic do_reset(input bit v);
        in  = v;
        rst = 1'b0;
        #1;
        check("rst_period", period_a | period_b, 32'd0);
        check("rst_flags", 32'({valid_a, valid_b, level_a, level_b, timeout_a, timeout_b, locked_a, locked_b}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #3;
        do_reset(1'b1);
        repeat (3) tick(1'b1);
        repeat (8) half(10);

        half(30);
        repeat (4) half(20);
        half(19);
        half(21);

        repeat (12) half(1);

        repeat (2) half(10);
        half(8);
        do_reset(1'b0);
        repeat (6) half(5);

        half(100); half(101); half(99); half(100); half(102);
        half(110); half(100);
        repeat (8) half($urandom_range(97, 104));
        half(200);

        repeat (40) half($urandom_range(1, 28));
        repeat (30) begin
            if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
            half($urandom_range(1, 24));
        end
        repeat (25) tick(in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
